// File: rtl/div3_serial_ctrl.sv
// div3_serial_ctrl: bit-serial divide-by-3 sequencer, MSB-first; DIV3_CHAIN_EN adds rem_in seeding and rem_in_err
module div3_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
`ifdef DIV3_CHAIN_EN
  input  logic [1:0]       rem_in,
  output logic             rem_in_err,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [1:0]       remainder,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_op, r_q;
  logic [1:0] r_rem, w_seed, w_rem;
  logic [CW-1:0] r_cnt;
  logic [2:0] w_t, w_tm;
  logic w_qbit, w_acc, w_last;
  assign w_t = {r_rem, r_op[WIDTH-1]};
  assign w_tm = w_t - 3'd3;
  assign w_qbit = w_t >= 3'd3;
  assign w_rem = w_qbit ? w_tm[1:0] : w_t[1:0];
  assign w_last = r_cnt == CW'(WIDTH - 1);
  assign w_acc = in_valid & in_ready & ~flush;
  assign quotient = r_q;
  assign remainder = r_rem;
`ifdef DIV3_CHAIN_EN
  assign w_seed = (rem_in == 2'b11) ? 2'b00 : rem_in;
`else
  assign w_seed = 2'b00;
`endif
  // next-state and handshake outputs; flush overrides every transition
  always_comb begin
    w_next = r_state;
    in_ready = r_state == IDLE;
    out_valid = r_state == DONE;
    busy = r_state == RUN;
    if (flush) w_next = IDLE;
    else if (r_state == IDLE && in_valid) w_next = RUN;
    else if (r_state == RUN && w_last) w_next = DONE;
    else if (r_state == DONE && out_ready) w_next = IDLE;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  // operand load, one recurrence step per RUN cycle; results hold until the next load
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_op <= '0;
      r_q <= '0;
      r_rem <= 2'b00;
      r_cnt <= '0;
    end else if (flush) begin
      r_cnt <= '0;
    end else if (w_acc) begin
      r_op <= dividend;
      r_rem <= w_seed;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_op <= r_op << 1;
      r_q <= {r_q[WIDTH-2:0], w_qbit};
      r_rem <= w_rem;
      r_cnt <= r_cnt + 1'b1;
    end
`ifdef DIV3_CHAIN_EN
  // sticky flag for an illegal 11 seed presented at accept
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rem_in_err <= 1'b0;
    else if (flush) rem_in_err <= 1'b0;
    else if (w_acc && rem_in == 2'b11) rem_in_err <= 1'b1;
`endif
endmodule

// File: tb/tb_div3_serial_ctrl.sv
// tb_div3_serial_ctrl: directed and random checks of div3_serial_ctrl with WIDTH=8
module tb_div3_serial_ctrl;
  localparam int W = 8;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, busy;
  logic [W-1:0] dividend = 0, quotient;
  logic [1:0] remainder;
`ifdef DIV3_CHAIN_EN
  logic [1:0] rem_in = 0;
  logic rem_in_err;
`endif
  int n_chk = 0, n_pass = 0;
  logic [7:0] cv [4] = '{8'd0, 8'd1, 8'd255, 8'd3};
  logic [7:0] cq [4] = '{8'd0, 8'd0, 8'd85, 8'd1};
  logic [1:0] cr [4] = '{2'd0, 2'd1, 2'd0, 2'd0};
  always #5 clk = ~clk;
  div3_serial_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .dividend(dividend),
`ifdef DIV3_CHAIN_EN
    .rem_in(rem_in), .rem_in_err(rem_in_err),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .busy(busy)
  );
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask
  always @(negedge clk) if (remainder === 2'b11) chk("rem_legal", 32'(remainder), 32'd0);
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_op(input logic [7:0] d, input int stall, output logic [7:0] q, output logic [1:0] r);
    int k;
    in_valid = 1;
    dividend = d;
    out_ready = 0;
    k = 0;
    while (!in_ready && k < 50) begin tick(); k++; end
    chk("accept_wait", k, 0);
    tick();
    in_valid = 0;
    chk("run_busy", busy, 1);
    chk("run_in_ready", in_ready, 0);
    k = 0;
    while (!out_valid && k < 50) begin tick(); k++; end
    chk("latency", k, W);
    q = quotient;
    r = remainder;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1;
      tick();
      chk("stall_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_q", quotient, q);
      chk("stall_r", remainder, r);
    end
    in_valid = 0;
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("ack_valid", out_valid, 0);
    chk("ack_in_ready", in_ready, 1);
    chk("hold_q", quotient, q);
  endtask
  initial begin
    logic [7:0] q, d;
    logic [1:0] r;
    int k, seen;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    rst_n = 1;
    tick();
    do_op(8'd200, 0, q, r);
    chk("d200_q", q, 66);
    chk("d200_r", r, 2);
    out_ready = 1;
    in_valid = 1;
    dividend = cv[0];
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) dividend = cv[i+1];
      else in_valid = 0;
      k = 0;
      while (!out_valid && k < 50) begin tick(); k++; end
      chk("b2b_lat", k, W);
      chk("b2b_q", quotient, cq[i]);
      chk("b2b_r", remainder, cr[i]);
      tick();
      chk("b2b_ready", in_ready, 1);
      tick();
      chk("b2b_busy", busy, i < 3);
    end
    out_ready = 0;
    do_op(8'd100, 5, q, r);
    chk("bp_q", q, 33);
    chk("bp_r", r, 1);
    in_valid = 1;
    dividend = 8'd90;
    tick();
    in_valid = 0;
    tick();
    tick();
    tick();
    flush = 1;
    tick();
    flush = 0;
    chk("flush_busy", busy, 0);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_valid", out_valid, 0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin tick(); if (out_valid) seen++; end
    chk("flush_no_result", seen, 0);
    flush = 1;
    in_valid = 1;
    tick();
    flush = 0;
    in_valid = 0;
    chk("flush_beats_valid", busy, 0);
    tick();
    chk("flush_no_accept", busy, 0);
    in_valid = 1;
    dividend = 8'd50;
    tick();
    in_valid = 0;
    k = 0;
    while (!out_valid && k < 50) begin tick(); k++; end
    chk("fd_lat", k, W);
    flush = 1;
    out_ready = 1;
    tick();
    flush = 0;
    out_ready = 0;
    chk("flush_done_valid", out_valid, 0);
    chk("flush_done_ready", in_ready, 1);
    do_op(8'd7, 0, q, r);
    chk("d7_q", q, 2);
    chk("d7_r", r, 1);
    in_valid = 1;
    dividend = 8'd255;
    tick();
    in_valid = 0;
    tick();
    tick();
    #2 rst_n = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_q", quotient, 0);
    chk("arst_r", remainder, 0);
    #2 rst_n = 1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin tick(); if (out_valid) seen++; end
    chk("arst_no_result", seen, 0);
`ifdef DIV3_CHAIN_EN
    rem_in = 2'd2;
    do_op(8'd0, 0, q, r);
    chk("chain_q", q, 170);
    chk("chain_r", r, 2);
    chk("chain_err0", rem_in_err, 0);
    rem_in = 2'd3;
    do_op(8'd200, 0, q, r);
    chk("chain_bad_q", q, 66);
    chk("chain_bad_r", r, 2);
    chk("chain_err1", rem_in_err, 1);
    rem_in = 2'd0;
    flush = 1;
    tick();
    flush = 0;
    chk("chain_err_clr", rem_in_err, 0);
`endif
    for (int i = 0; i < 1000; i++) begin
      d = 8'($urandom);
      do_op(d, $urandom_range(0, 3), q, r);
      chk("rnd_q", q, d / 3);
      chk("rnd_r", r, d % 3);
      chk("rnd_sum", q * 3 + r, d);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
